// File: rtl/mem_arbiter_n.sv
// N-requester memory arbiter: one priority master that may preempt
// round-robin bursts of the others, with a saturating preemption counter.
module mem_arbiter_n #(
  parameter int N_REQ      = 4,
  parameter int PRIO_ID    = 0,
  parameter int MAX_BURST  = 2,
  parameter int PREEMPT_EN = 1,
  parameter int CNT_W      = 16,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             preempted,
  output logic [CNT_W-1:0] nb_interrupts
);

  typedef enum logic [1:0] {IDLE, GNT_PRIO, GNT_RR, GNT_PRE} state_t;

  state_t           state_reg, state_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic [ID_W-1:0]  last_rr_reg, last_rr_next;
  logic [7:0]       beat_reg, beat_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic             busy_reg, preempted_reg;

  logic [N_REQ-1:0] rr_req;
  logic             arb_found;
  logic [ID_W-1:0]  arb_id;
  state_t           arb_state;
  logic [ID_W-1:0]  arb_sel;
  logic             take_arb;
  int               idx;

  // Priority master never competes in the round-robin search.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rr_req
    assign rr_req[gi] = (gi == PRIO_ID) ? 1'b0 : req[gi];
  end

  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_rr_reg) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!arb_found && rr_req[idx]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    arb_state = IDLE;
    arb_sel   = '0;
    if (req[PRIO_ID]) begin
      arb_state = GNT_PRIO;
      arb_sel   = ID_W'(PRIO_ID);
    end else if (arb_found) begin
      arb_state = GNT_RR;
      arb_sel   = arb_id;
    end
  end

  always_comb begin
    state_next   = state_reg;
    id_next      = id_reg;
    last_rr_next = last_rr_reg;
    cnt_next     = cnt_reg;
    beat_next    = (beat_reg == 8'hFF) ? beat_reg : beat_reg + 8'd1;
    take_arb     = 1'b0;
    case (state_reg)
      IDLE:     take_arb = 1'b1;
      GNT_PRIO: take_arb = done[PRIO_ID];
      GNT_RR: begin
        // A normal end (done or limit) wins over a simultaneous preempt.
        if (done[id_reg] || beat_reg == 8'(MAX_BURST)) begin
          take_arb = 1'b1;
        end else if (PREEMPT_EN != 0 && req[PRIO_ID]) begin
          state_next = GNT_PRE;
          id_next    = ID_W'(PRIO_ID);
          beat_next  = 8'd1;
          if (cnt_reg != '1) cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GNT_PRE:  take_arb = done[PRIO_ID] || beat_reg == 8'(MAX_BURST);
      default:  take_arb = 1'b1;
    endcase
    if (take_arb) begin
      state_next = arb_state;
      id_next    = arb_sel;
      beat_next  = (arb_state == IDLE) ? 8'd0 : 8'd1;
      if (arb_state == GNT_RR) last_rr_next = arb_sel;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant_next[gi] = (state_next != IDLE) && (id_next == ID_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      id_reg        <= '0;
      last_rr_reg   <= ID_W'(N_REQ - 1);
      beat_reg      <= 8'd0;
      cnt_reg       <= '0;
      grant_reg     <= '0;
      busy_reg      <= 1'b0;
      preempted_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      id_reg        <= id_next;
      last_rr_reg   <= last_rr_next;
      beat_reg      <= beat_next;
      cnt_reg       <= cnt_next;
      grant_reg     <= grant_next;
      busy_reg      <= (state_next != IDLE);
      preempted_reg <= (state_next == GNT_PRE);
    end
  end

  assign grant         = grant_reg;
  assign grant_id      = id_reg;
  assign busy          = busy_reg;
  assign preempted     = preempted_reg;
  assign nb_interrupts = cnt_reg;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed-vector bench for mem_arbiter_n: default config, a 2-bit counter
// instance for saturation, and a preemption-disabled instance.
module tb_mem_arbiter_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] req_a, done_a, grant_a;
  logic [1:0] id_a;
  logic       busy_a, pre_a;
  logic [15:0] nb_a;

  logic [3:0] req_b, done_b, grant_b;
  logic [1:0] id_b;
  logic       busy_b, pre_b;
  logic [1:0] nb_b;

  logic [3:0] req_c, done_c, grant_c;
  logic [1:0] id_c;
  logic       busy_c, pre_c;
  logic [15:0] nb_c;

  mem_arbiter_n #(.N_REQ(4), .PRIO_ID(0), .MAX_BURST(2), .PREEMPT_EN(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .done(done_a), .grant(grant_a),
    .grant_id(id_a), .busy(busy_a), .preempted(pre_a), .nb_interrupts(nb_a));

  mem_arbiter_n #(.N_REQ(4), .PRIO_ID(0), .MAX_BURST(2), .PREEMPT_EN(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .done(done_b), .grant(grant_b),
    .grant_id(id_b), .busy(busy_b), .preempted(pre_b), .nb_interrupts(nb_b));

  mem_arbiter_n #(.N_REQ(4), .PRIO_ID(0), .MAX_BURST(2), .PREEMPT_EN(0), .CNT_W(16)) u_dut_c (
    .clk(clk), .reset(reset), .req(req_c), .done(done_c), .grant(grant_c),
    .grant_id(id_c), .busy(busy_c), .preempted(pre_c), .nb_interrupts(nb_c));

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_seq [7] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0010};
  logic [1:0] rr_ids [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};
  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    reset = 1'b1;
    req_a = '0; done_a = '0; req_b = '0; done_b = '0; req_c = '0; done_c = '0;
    // Reset with random activity on the inputs
    for (int i = 0; i < 3; i++) begin
      req_a = 4'($urandom); done_a = 4'($urandom);
      step();
      check("rst_grant", grant_a, 4'b0000);
      check("rst_busy", busy_a, 1'b0);
    end
    reset = 1'b0; req_a = '0; done_a = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_grant", grant_a, 4'b0000);
      check("idle_busy", busy_a, 1'b0);
      check("idle_nb", nb_a, 16'd0);
    end

    // Round-robin with bursts of two
    req_a = 4'b1110;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("rr_grant%0d", i), grant_a, rr_seq[i]);
      check($sformatf("rr_id%0d", i), id_a, rr_ids[i]);
    end
    req_a = 4'b0000;
    step(); check("rr_reqdrop_hold", grant_a, 4'b0010);
    step(); check("rr_to_idle", grant_a, 4'b0000);
    check("rr_idle_id", id_a, 2'd0);

    // Preemption of master 2 in its first beat
    req_a = 4'b0100;
    step(); check("pre_m2", grant_a, 4'b0100);
    req_a = 4'b0101;
    step(); check("pre_grant", grant_a, 4'b0001);
    check("pre_flag", pre_a, 1'b1);
    check("pre_nb", nb_a, 16'd1);
    req_a = 4'b0100;
    step(); check("pre_beat2", grant_a, 4'b0001);
    check("pre_flag2", pre_a, 1'b1);
    step(); check("pre_resume", grant_a, 4'b0100);
    check("pre_flag_clr", pre_a, 1'b0);
    req_a = 4'b0000; done_a = 4'b0010;
    step(); check("foreign_done_ign", grant_a, 4'b0100);
    done_a = 4'b0000;
    step(); check("pre_end_idle", grant_a, 4'b0000);

    // Priority normal grant with no burst limit
    req_a = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("prio_grant%0d", i), grant_a, 4'b0001);
      check($sformatf("prio_flag%0d", i), pre_a, 1'b0);
    end
    req_a = 4'b0010; done_a = 4'b0001;
    step(); check("prio_done_arb", grant_a, 4'b0010);
    req_a = 4'b0000; done_a = 4'b0010;
    step(); check("rr_done_idle", grant_a, 4'b0000);

    // done together with priority request: normal end, no count
    req_a = 4'b0100; done_a = 4'b0000;
    step(); check("sim_m2", grant_a, 4'b0100);
    req_a = 4'b0101; done_a = 4'b0100;
    step(); check("sim_done_grant", grant_a, 4'b0001);
    check("sim_done_flag", pre_a, 1'b0);
    check("sim_done_nb", nb_a, 16'd1);
    req_a = 4'b0000; done_a = 4'b0001;
    step(); check("sim_done_idle", grant_a, 4'b0000);

    // burst limit together with priority request: normal end, no count
    req_a = 4'b0100; done_a = 4'b0000;
    step(); check("lim_m2_b1", grant_a, 4'b0100);
    step(); check("lim_m2_b2", grant_a, 4'b0100);
    req_a = 4'b0001;
    step(); check("lim_grant", grant_a, 4'b0001);
    check("lim_flag", pre_a, 1'b0);
    check("lim_nb", nb_a, 16'd1);
    req_a = 4'b0000; done_a = 4'b0001;
    step(); check("lim_idle", grant_a, 4'b0000);
    done_a = 4'b0000;

    // Counter saturation on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      req_b = 4'b0100; done_b = 4'b0000;
      step();
      req_b = 4'b0101;
      step(); check($sformatf("sat_pre%0d", i), grant_b, 4'b0001);
      req_b = 4'b0000; done_b = 4'b0001;
      step(); check($sformatf("sat_nb%0d", i), nb_b, sat_exp[i]);
    end
    done_b = 4'b0000;

    // Preemption disabled: master 2 keeps its full burst
    req_c = 4'b0100;
    step(); check("nopre_b1", grant_c, 4'b0100);
    req_c = 4'b0101;
    step(); check("nopre_b2", grant_c, 4'b0100);
    check("nopre_flag", pre_c, 1'b0);
    step(); check("nopre_prio", grant_c, 4'b0001);
    check("nopre_nb", nb_c, 16'd0);
    req_c = 4'b0000; done_c = 4'b0001;
    step(); check("nopre_idle", grant_c, 4'b0000);
    done_c = 4'b0000;

    // Reset mid-burst abandons the grant and clears the counter
    req_a = 4'b0100;
    step(); check("rstmid_grant", grant_a, 4'b0100);
    reset = 1'b1;
    step(); check("rstmid_clear", grant_a, 4'b0000);
    check("rstmid_nb", nb_a, 16'd0);
    check("rstmid_busy", busy_a, 1'b0);
    reset = 1'b0; req_a = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
